// File: rtl/ub_pkg.sv
// Shared constants, typedefs and read-engine state encoding for the unified-buffer access scheduler.
package ub_pkg;

  localparam int DATA_WIDTH = 128;
  localparam int DEPTH      = 256;
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1;

  typedef logic [ADDR_WIDTH-1:0] ub_addr_t;
  typedef logic [DATA_WIDTH-1:0] ub_row_t;
  typedef logic [LEN_WIDTH-1:0]  ub_len_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } rd_state_t;

endpackage

// File: rtl/ub_rr_arbiter.sv
// Two-way round-robin arbiter with combinational grant; the pointer only moves on contended grants.
module ub_rr_arbiter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;
  logic ptr_d;

  // ptr_q == 0 means requester 0 wins the next tie.
  always_comb begin
    gnt_o = req_i;
    ptr_d = ptr_q;
    if (&req_i) begin
      gnt_o = ptr_q ? 2'b10 : 2'b01;
      ptr_d = ~ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ub_access_scheduler.sv
// Unified-buffer BRAM scheduler: round-robin write port sharing plus a read burst engine.
// Define UB_RAW_BYPASS_EN to forward same-cycle write data to a colliding read (new-data semantics).
module ub_access_scheduler
  import ub_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr0_req,
  input  logic [ADDR_WIDTH-1:0] wr0_addr,
  input  logic [DATA_WIDTH-1:0] wr0_data,
  output logic                  wr0_gnt,
  input  logic                  wr1_req,
  input  logic [ADDR_WIDTH-1:0] wr1_addr,
  input  logic [DATA_WIDTH-1:0] wr1_data,
  output logic                  wr1_gnt,
  input  logic                  rd_start,
  input  logic [ADDR_WIDTH-1:0] rd_base,
  input  logic [LEN_WIDTH-1:0]  rd_len,
  output logic                  rd_busy,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_done,
  output logic                  bram_wea,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [DATA_WIDTH-1:0] bram_dina,
  output logic                  bram_enb,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  input  logic [DATA_WIDTH-1:0] bram_doutb
);

  logic [1:0] arb_gnt;
  rd_state_t  state_q;
  ub_addr_t   addr_q;
  ub_len_t    cnt_q;
  logic       enb_q;
  logic       valid_q;
  logic       done_q;
  ub_row_t    data_q;
  ub_row_t    row_d;

  ub_rr_arbiter u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   ({wr1_req, wr0_req}),
    .gnt_o   (arb_gnt)
  );

  // Grants and the write strobe are forced low in reset so every output reads 0.
  always_comb begin
    wr0_gnt    = arb_gnt[0] & reset_n;
    wr1_gnt    = arb_gnt[1] & reset_n;
    bram_wea   = (wr0_req | wr1_req) & reset_n;
    bram_addra = '0;
    bram_dina  = '0;
    if (wr1_gnt) begin
      bram_addra = wr1_addr;
      bram_dina  = wr1_data;
    end else if (wr0_gnt) begin
      bram_addra = wr0_addr;
      bram_dina  = wr0_data;
    end
  end

`ifdef UB_RAW_BYPASS_EN
  logic raw_hit;
  assign raw_hit = bram_wea & enb_q & (bram_addra == addr_q);
  assign row_d   = raw_hit ? bram_dina : bram_doutb;
`else
  assign row_d = bram_doutb;
`endif

  assign bram_enb   = enb_q;
  assign bram_addrb = addr_q;
  assign rd_busy    = (state_q != IDLE);
  assign rd_valid   = valid_q;
  assign rd_data    = data_q;
  assign rd_done    = done_q;

  // The BRAM captures the issued row at the negedge, so it is registered at the following posedge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      enb_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      done_q  <= 1'b0;
      valid_q <= enb_q;
      if (enb_q) begin
        data_q <= row_d;
      end
      case (state_q)
        IDLE: begin
          if (rd_start) begin
            if (rd_len != '0) begin
              state_q <= ISSUE;
              enb_q   <= 1'b1;
              addr_q  <= rd_base;
              cnt_q   <= rd_len;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (cnt_q == LEN_WIDTH'(1)) begin
            enb_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= DRAIN;
          end else begin
            cnt_q  <= cnt_q - 1'b1;
            addr_q <= addr_q + 1'b1;
          end
        end
        DRAIN: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
